systolic_feed_controller: RTL and testbench
===========================================

SYSTOLIC_FEED_CONTROLLER -- requirements
Module: systolic_feed_controller

Interface
REQ-001 SHALL have parameter MATRIX_WIDTH, default 14, giving the number of byte lanes per row.
REQ-002 SHALL have parameter ADDR_WIDTH, default 24, giving the buffer address width.
REQ-003 SHALL have port clk  input  1  clock; all logic on the rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port start  input  1  launches one feed job when idle.
REQ-006 SHALL have port base_addr  input  ADDR_WIDTH  first row address, sampled with start.
REQ-007 SHALL have port row_count  input  16  rows in the job, sampled with start.
REQ-008 SHALL have port stall  input  1  downstream hold request.
REQ-009 SHALL have port buf_rd_en  output  1  buffer read strobe.
REQ-010 SHALL have port buf_rd_addr  output  ADDR_WIDTH  buffer read address.
REQ-011 SHALL have port buf_rd_data  input  MATRIX_WIDTH x byte_type  read data, valid exactly 1 cycle after buf_rd_en.
REQ-012 SHALL have port setup_enable  output  1  advance strobe to the systolic data setup unit.
REQ-013 SHALL have port setup_data  output  MATRIX_WIDTH x byte_type  row presented to the setup unit.
REQ-014 SHALL have port row_valid  output  1  setup_data is a real row, not a drain zero.
REQ-015 SHALL have port busy  output  1  job in progress.
REQ-016 SHALL have port done  output  1  one-cycle job-complete pulse.

Function
REQ-017 SHALL implement the states IDLE, FETCH, DRAIN and FINISH.
REQ-018 IDLE: start=1 SHALL latch base_addr and row_count, then enter FETCH; if row_count=0, it SHALL enter FINISH instead.
REQ-019 FETCH: each cycle with stall=0 SHALL assert buf_rd_en and issue consecutive addresses base_addr, base_addr+1, and so on.
REQ-020 Address arithmetic SHALL wrap modulo 2^ADDR_WIDTH.
REQ-021 FETCH SHALL leave for DRAIN once row_count reads have issued and the last row has been presented.
REQ-022 The data-return cycle SHALL set setup_data=buf_rd_data, setup_enable=!stall and row_valid=!stall.
REQ-023 If stall=1 on a data-return cycle, a 1-entry hold register SHALL capture the data. It SHALL be presented with setup_enable=1 on the first stall=0 cycle, and a new read MAY issue in that same cycle.
REQ-024 While stall=1, there SHALL be no read issue, no setup_enable and no counter advance.
REQ-025 DRAIN SHALL emit MATRIX_WIDTH-1 enabled cycles with setup_data all-zero and row_valid=0, counting only stall=0 cycles, so that the skew empties; it SHALL then enter FINISH.
REQ-026 FINISH SHALL assert done for 1 cycle with busy=0, then enter IDLE.
REQ-027 busy SHALL be 1 in FETCH and DRAIN and 0 otherwise.
REQ-028 Without stalls, with start sampled in cycle 0 and N>0: reads SHALL occur in cycles 1..N, real rows in cycles 2..N+1, drain in cycles N+2..N+MATRIX_WIDTH, and done in cycle N+MATRIX_WIDTH+1.
REQ-029 A start asserted while busy=1 or in FINISH SHALL be ignored.

Reset
REQ-030 rst SHALL force IDLE, clear the hold register and the counters, and drive buf_rd_en, setup_enable, row_valid, busy and done to 0, and buf_rd_addr and setup_data to 0.
REQ-031 rst mid-job SHALL abort the job with no done pulse; an in-flight read return SHALL be discarded.

Configuration
REQ-032 SYSTOLIC_FEED_DRAIN_EN defined: DRAIN SHALL be implemented as in REQ-025.
REQ-033 SYSTOLIC_FEED_DRAIN_EN undefined: FETCH SHALL go directly to FINISH after the last real row, with done in cycle N+2 and no zero rows.

Structure
REQ-034 byte_type and the typedef feed_state_t (IDLE, FETCH, DRAIN, FINISH) SHALL reside in tpu_pkg.
REQ-035 The block SHALL be a single module with no sub-modules; it SHALL instantiate neither the buffer nor the setup unit.

Verification (MATRIX_WIDTH=4)
REQ-036 base 0x10, N=3, no stall -> rd_addr 0x10/0x11/0x12 in cycles 1-3; row_valid in cycles 2-4; zero enables in cycles 5-7; done in cycle 8.
REQ-037 Same job with stall=1 in cycle 2 only -> cycle-2 data held and presented in cycle 3 together with the read of 0x11; done in cycle 9; row order preserved.
REQ-038 N=0 -> no buf_rd_en; done in cycle 1.
REQ-039 base 0xFFFFFF, N=2 -> addresses 0xFFFFFF then 0x000000.
REQ-040 start pulsed in cycle 4 of a busy job -> ignored; exactly one done.
REQ-041 rst in cycle 3 -> all outputs 0 in cycle 4; no done; next start behaves as in REQ-036.

Source files
------------

// File: rtl/tpu_pkg.sv
// rtl/tpu_pkg.sv - shared TPU types for the systolic feed path
package tpu_pkg;

    typedef logic [7:0] byte_type;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FETCH  = 2'd1,
        DRAIN  = 2'd2,
        FINISH = 2'd3
    } feed_state_t;

endpackage

// File: rtl/systolic_feed_controller.sv
// rtl/systolic_feed_controller.sv - streams buffer rows into the systolic setup unit
// Optional SYSTOLIC_FEED_DRAIN_EN appends MATRIX_WIDTH-1 zero rows to flush the skew.
module systolic_feed_controller
    import tpu_pkg::*;
#(
    parameter int MATRIX_WIDTH = 14,
    parameter int ADDR_WIDTH   = 24
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             start,
    input  logic [ADDR_WIDTH-1:0]            base_addr,
    input  logic [15:0]                      row_count,
    input  logic                             stall,
    output logic                             buf_rd_en,
    output logic [ADDR_WIDTH-1:0]            buf_rd_addr,
    input  byte_type [MATRIX_WIDTH-1:0]      buf_rd_data,
    output logic                             setup_enable,
    output byte_type [MATRIX_WIDTH-1:0]      setup_data,
    output logic                             row_valid,
    output logic                             busy,
    output logic                             done
);

`ifdef SYSTOLIC_FEED_DRAIN_EN
    localparam int DRAIN_CYCLES = MATRIX_WIDTH - 1;
    localparam int DW           = $clog2(MATRIX_WIDTH) + 1;
    logic [DW-1:0] drain_q, drain_d;
`endif

    feed_state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]        addr_q, addr_d;
    logic [15:0]                  count_q, count_d;
    logic [15:0]                  issued_q, issued_d;
    logic [15:0]                  rows_q, rows_d;
    logic                         rd_pend_q, rd_pend_d;
    logic                         hold_vld_q, hold_vld_d;
    byte_type [MATRIX_WIDTH-1:0]  hold_q, hold_d;

    logic rd_issue;
    logic row_present;

    assign rd_issue    = (state_q == FETCH) && !stall && (issued_q != count_q);
    assign row_present = (state_q == FETCH) && !stall && (hold_vld_q || rd_pend_q);

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        count_d    = count_q;
        issued_d   = issued_q;
        rows_d     = rows_q;
        rd_pend_d  = rd_issue;
        hold_vld_d = hold_vld_q;
        hold_d     = hold_q;
`ifdef SYSTOLIC_FEED_DRAIN_EN
        drain_d    = drain_q;
`endif

        // A stalled return parks in the hold slot; reads pause during stall so it never overflows.
        if (rd_pend_q && stall) begin
            hold_vld_d = 1'b1;
            hold_d     = buf_rd_data;
        end else if (row_present && hold_vld_q) begin
            hold_vld_d = 1'b0;
        end

        if (rd_issue) begin
            addr_d   = addr_q + 1'b1;
            issued_d = issued_q + 16'd1;
        end
        if (row_present) begin
            rows_d = rows_q + 16'd1;
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    addr_d   = base_addr;
                    count_d  = row_count;
                    issued_d = '0;
                    rows_d   = '0;
                    state_d  = (row_count == 16'd0) ? FINISH : FETCH;
                end
            end
            FETCH: begin
                if (row_present && (rows_q + 16'd1 == count_q)) begin
`ifdef SYSTOLIC_FEED_DRAIN_EN
                    state_d = (DRAIN_CYCLES > 0) ? DRAIN : FINISH;
                    drain_d = '0;
`else
                    state_d = FINISH;
`endif
                end
            end
            DRAIN: begin
`ifdef SYSTOLIC_FEED_DRAIN_EN
                if (!stall) begin
                    if (drain_q == DW'(DRAIN_CYCLES - 1)) begin
                        state_d = FINISH;
                    end else begin
                        drain_d = drain_q + 1'b1;
                    end
                end
`else
                state_d = FINISH;
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            count_q    <= '0;
            issued_q   <= '0;
            rows_q     <= '0;
            rd_pend_q  <= 1'b0;
            hold_vld_q <= 1'b0;
            hold_q     <= '0;
`ifdef SYSTOLIC_FEED_DRAIN_EN
            drain_q    <= '0;
`endif
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            count_q    <= count_d;
            issued_q   <= issued_d;
            rows_q     <= rows_d;
            rd_pend_q  <= rd_pend_d;
            hold_vld_q <= hold_vld_d;
            hold_q     <= hold_d;
`ifdef SYSTOLIC_FEED_DRAIN_EN
            drain_q    <= drain_d;
`endif
        end
    end

    // Outputs are decoded from state, so they are masked while reset is held.
    always_comb begin
        buf_rd_en    = !rst && rd_issue;
        buf_rd_addr  = rst ? '0 : addr_q;
        setup_enable = !rst && (row_present || ((state_q == DRAIN) && !stall));
        row_valid    = !rst && row_present;
        busy         = !rst && ((state_q == FETCH) || (state_q == DRAIN));
        done         = !rst && (state_q == FINISH);
        setup_data   = '0;
        if (!rst) begin
            if (hold_vld_q) begin
                setup_data = hold_q;
            end else if (rd_pend_q) begin
                setup_data = buf_rd_data;
            end
        end
    end

endmodule

// File: tb/tb_systolic_feed_controller.sv
// tb/tb_systolic_feed_controller.sv - randomized self-checking bench for systolic_feed_controller
module tb_systolic_feed_controller;
    import tpu_pkg::*;

    localparam int MW = 4;
    localparam int AW = 24;
`ifdef SYSTOLIC_FEED_DRAIN_EN
    localparam int DR = MW - 1;
`else
    localparam int DR = 0;
`endif

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  start;
    logic [AW-1:0]         base_addr;
    logic [15:0]           row_count;
    logic                  stall;
    logic                  buf_rd_en;
    logic [AW-1:0]         buf_rd_addr;
    byte_type [MW-1:0]     buf_rd_data;
    logic                  setup_enable;
    byte_type [MW-1:0]     setup_data;
    logic                  row_valid;
    logic                  busy;
    logic                  done;

    int n_chk  = 0;
    int n_pass = 0;
    bit stall_pat [512];

    systolic_feed_controller #(.MATRIX_WIDTH(MW), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
        .row_count(row_count), .stall(stall), .buf_rd_en(buf_rd_en),
        .buf_rd_addr(buf_rd_addr), .buf_rd_data(buf_rd_data),
        .setup_enable(setup_enable), .setup_data(setup_data),
        .row_valid(row_valid), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    function automatic logic [MW*8-1:0] mem_row(input logic [AW-1:0] a);
        logic [MW*8-1:0] r;
        for (int i = 0; i < MW; i++) begin
            r[i*8 +: 8] = (a[7:0] ^ a[15:8] ^ a[23:16]) + 8'(i * 53 + 17);
        end
        return r;
    endfunction

    // Buffer returns the addressed row one cycle after a read; junk otherwise.
    always @(posedge clk) begin
        buf_rd_data <= buf_rd_en ? mem_row(buf_rd_addr) : MW*8'($urandom);
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic check_quiet(input string tag);
        chk({tag, "_rd_en"}, buf_rd_en, 0);
        chk({tag, "_rd_addr"}, buf_rd_addr, 0);
        chk({tag, "_setup_en"}, setup_enable, 0);
        chk({tag, "_setup_data"}, setup_data, 0);
        chk({tag, "_row_valid"}, row_valid, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
    endtask

    // Every stall cycle inside a job delays completion by exactly one cycle.
    function automatic int expected_done(input int n);
        int need;
        int c;
        if (n == 0) return 1;
        need = n + 1 + DR;
        c = 1;
        while (need > 0) begin
            if (!stall_pat[c]) need--;
            c++;
        end
        return c;
    endfunction

    task automatic run_job(input logic [AW-1:0] base, input int n, input int again_cyc, input int rst_cyc);
        logic [AW-1:0]   addrs [$];
        logic [MW*8-1:0] rows  [$];
        logic [AW-1:0]   ea;
        int drains  = 0;
        int dones   = 0;
        int done_at = -1;
        int exp_done;
        int limit;
        exp_done = expected_done(n);
        limit    = exp_done + 6;
        @(negedge clk);
        start = 1'b1; base_addr = base; row_count = 16'(n); stall = stall_pat[0];
        for (int cyc = 0; cyc <= limit; cyc++) begin
            if (cyc > 0) begin
                @(negedge clk);
                start = (cyc == again_cyc);
                if (start) begin
                    base_addr = AW'($urandom);
                    row_count = 16'($urandom_range(1, 5));
                end
                stall = stall_pat[cyc];
                rst   = (cyc == rst_cyc);
            end
            #1;
            if (rst_cyc >= 0 && cyc == rst_cyc + 1) check_quiet("post_rst");
            if (buf_rd_en) begin
                addrs.push_back(buf_rd_addr);
                chk("rd_while_stall", stall, 0);
            end
            if (setup_enable) begin
                chk("en_while_stall", stall, 0);
                if (row_valid) rows.push_back(setup_data);
                else begin
                    drains++;
                    chk("drain_zero", setup_data, 0);
                end
            end
            if (done) begin
                dones++;
                done_at = cyc;
                chk("busy_at_done", busy, 0);
            end
        end
        start = 1'b0; stall = 1'b0; rst = 1'b0;
        if (rst_cyc >= 0) begin
            chk("rst_no_done", dones, 0);
        end else begin
            chk("n_reads", addrs.size(), n);
            for (int i = 0; i < n && i < addrs.size(); i++) begin
                ea = base + AW'(i);
                chk("rd_addr", addrs[i], ea);
            end
            chk("n_rows", rows.size(), n);
            for (int i = 0; i < n && i < rows.size(); i++) begin
                ea = base + AW'(i);
                chk("row_data", rows[i], mem_row(ea));
            end
            chk("n_drain", drains, DR);
            chk("n_done", dones, 1);
            chk("done_cycle", done_at, exp_done);
        end
    endtask

    task automatic clear_stalls();
        for (int i = 0; i < 512; i++) stall_pat[i] = 1'b0;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; stall = 1'b0; base_addr = '0; row_count = '0;
        clear_stalls();
        repeat (2) @(negedge clk);
        #1 check_quiet("in_rst");
        @(negedge clk);
        rst = 1'b0;
        #1 check_quiet("idle");

        run_job(24'h000010, 3, -1, -1);
        stall_pat[2] = 1'b1;
        run_job(24'h000010, 3, -1, -1);
        clear_stalls();
        run_job(24'h000000, 0, -1, -1);
        run_job(24'hFFFFFF, 2, -1, -1);
        run_job(24'h000010, 3, 4, -1);
        run_job(24'h000020, 3, expected_done(3), -1);
        run_job(24'h000010, 3, -1, 3);
        run_job(24'h000010, 3, -1, -1);

        for (int j = 0; j < 20; j++) begin
            int n;
            int ed;
            for (int i = 0; i < 512; i++) stall_pat[i] = ($urandom_range(0, 2) == 0);
            n  = $urandom_range(0, 12);
            ed = expected_done(n);
            run_job(AW'($urandom), n, (j % 3 == 0) ? $urandom_range(1, ed) : -1, -1);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
